spi_device: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) slave front end, oversampled in the clk domain.

---
 rtl/synchronizer.sv | 24 ++
 rtl/spi_device.sv | 147 ++++++++++++++
 tb/tb_spi_device.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/synchronizer.sv
// Single-bit pin synchroniser: STAGES flops in series, preset to RESET_VALUE.
module synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RESET_VALUE}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_device.sv
// SPI mode-0 slave front end oversampled in the clk domain: byte deserialiser
// for COPI, byte serialiser for CIPO with a one-deep response holding register.
module spi_device #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_copi,
  output logic       spi_cipo,
  output logic       spi_cipo_oe,
  output logic       cs_n,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t              state;
  logic                sck_sync;
  logic                cs_sync;
  logic                copi_sync;
  logic                sck_hist;
  logic                cs_hist;
  logic [CNT_W-1:0]    bit_count;
  logic [BYTE_W-1:0]   rx_shift;
  logic [BYTE_W-1:0]   tx_shift;
  logic [BYTE_W-1:0]   holding;
  logic                tx_pending;
  logic                rx_done;

  logic                sck_rise;
  logic                sck_fall;
  logic                cs_fall;
  logic                cs_rise;
  logic                last_bit;
  logic                byte_start;

  synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_sck),
    .q       (sck_sync)
  );

  synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_cs_n),
    .q       (cs_sync)
  );

  synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_copi (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi_copi),
    .q       (copi_sync)
  );

  // Edge pulses; SCK edges only count while the chip is selected.
  assign sck_rise = sck_sync & ~sck_hist & ~cs_sync;
  assign sck_fall = ~sck_sync & sck_hist & ~cs_sync;
  assign cs_fall  = cs_hist & ~cs_sync;
  assign cs_rise  = ~cs_hist & cs_sync;
  assign last_bit = (bit_count == CNT_W'(BYTE_W - 1));

  // A new transmit byte is loaded on frame entry and on every byte wrap.
  assign byte_start = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && !cs_rise && sck_rise && last_bit);

  assign cs_n     = cs_sync;
  assign spi_cipo = tx_shift[BYTE_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sck_hist    <= 1'b0;
      cs_hist     <= 1'b1;
      bit_count   <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      holding     <= '0;
      tx_pending  <= 1'b0;
      rx_done     <= 1'b0;
      rx_data     <= '0;
      rx_strobe   <= 1'b0;
      spi_cipo_oe <= 1'b0;
    end else begin
      sck_hist  <= sck_sync;
      cs_hist   <= cs_sync;
      rx_done   <= 1'b0;
      rx_strobe <= rx_done;

      // Writes outside a byte start park in the holding register.
      if (tx_strobe && !byte_start) begin
        holding    <= tx_data;
        tx_pending <= 1'b1;
      end

      if (byte_start) begin
        tx_shift   <= tx_strobe ? tx_data : (tx_pending ? holding : '0);
        tx_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            spi_cipo_oe <= 1'b1;
            bit_count   <= '0;
            rx_shift    <= '0;
          end
        end
        ACTIVE: begin
          // Deselect wins over any SCK edge in the same cycle.
          if (cs_rise) begin
            state       <= IDLE;
            spi_cipo_oe <= 1'b0;
            bit_count   <= '0;
            rx_shift    <= '0;
          end else if (sck_rise) begin
            rx_shift  <= {rx_shift[BYTE_W-2:0], copi_sync};
            bit_count <= bit_count + CNT_W'(1);
            if (last_bit) begin
              rx_data <= {rx_shift[BYTE_W-2:0], copi_sync};
              rx_done <= 1'b1;
            end
          end else if (sck_fall && (bit_count != '0)) begin
            // No shift on the fall after bit 8: the freshly loaded MSB stays out.
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device: SPI master model with a receive scoreboard.
module tb_spi_device;

  localparam int unsigned SYNC_STAGES = 2;

  logic       clk;
  logic       reset_n;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_copi;
  logic       spi_cipo;
  logic       spi_cipo_oe;
  logic       cs_n;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] tx_data;
  logic       tx_strobe;

  int         n_cmp;
  int         n_err;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx;
  logic [7:0] miso;
  logic       prev_strobe;
  time        last_rise_t;

  spi_device #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_copi    (spi_copi),
    .spi_cipo    (spi_cipo),
    .spi_cipo_oe (spi_cipo_oe),
    .cs_n        (cs_n),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .tx_data     (tx_data),
    .tx_strobe   (tx_strobe)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Receive scoreboard: every strobe must match the next queued byte and latency.
  always @(negedge clk) begin
    if (reset_n && rx_strobe) begin
      chk("rx_strobe_back_to_back", 32'(prev_strobe), 32'd0);
      if (rx_q.size() == 0) begin
        chk("unexpected_rx_strobe", 32'(rx_strobe), 32'd0);
      end else begin
        exp_rx = rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
        chk("rx_latency", 32'(($time - last_rise_t) / 2), 32'(SYNC_STAGES + 2));
      end
    end
    prev_strobe = rx_strobe;
  end

  // Clocks nbits of mosi; optionally writes bs_data on the byte-start cycle after bit 8.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input logic bs_en,
                      input logic [7:0] bs_data, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_copi = mosi[7-i];
      repeat (4) @(negedge clk);
      rd[7-i] = spi_cipo;
      spi_sck = 1'b1;
      if (i == 7) last_rise_t = $time;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == 7 && bs_en && k == 2) begin
          tx_data   = bs_data;
          tx_strobe = 1'b1;
        end
        if (k == 3) tx_strobe = 1'b0;
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data   = d;
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("cs_n_low", 32'(cs_n), 32'd0);
    chk("oe_active", 32'(spi_cipo_oe), 32'd1);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("cs_n_high", 32'(cs_n), 32'd1);
    chk("oe_idle", 32'(spi_cipo_oe), 32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    prev_strobe = 1'b0;
    last_rise_t = 0;
    reset_n     = 1'b0;
    spi_sck     = 1'b0;
    spi_cs_n    = 1'b1;
    spi_copi    = 1'b0;
    tx_data     = '0;
    tx_strobe   = 1'b0;

    // 1: reset held while the pins toggle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      spi_sck  = ~spi_sck;
      spi_cs_n = i[0];
      spi_copi = i[1];
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_rx_strobe", 32'(rx_strobe), 32'd0);
      chk("rst_cipo", 32'(spi_cipo), 32'd0);
      chk("rst_oe", 32'(spi_cipo_oe), 32'd0);
    end
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_rx_data", 32'(rx_data), 32'h00);

    // 2: two bytes in one frame
    cs_begin();
    rx_q.push_back(8'h05);
    xfer(8'h05, 8, 1'b0, 8'h00, miso);
    rx_q.push_back(8'hA5);
    xfer(8'hA5, 8, 1'b0, 8'h00, miso);
    cs_end();

    // 3: response written before select, then an empty second byte
    tx_write(8'h3C);
    cs_begin();
    rx_q.push_back(8'h12);
    xfer(8'h12, 8, 1'b0, 8'h00, miso);
    chk("tx_preloaded", 32'(miso), 32'h3C);
    rx_q.push_back(8'h34);
    xfer(8'h34, 8, 1'b0, 8'h00, miso);
    chk("tx_empty", 32'(miso), 32'h00);
    cs_end();

    // 4: partial byte abandoned, then a clean frame
    cs_begin();
    xfer(8'hFF, 5, 1'b0, 8'h00, miso);
    cs_end();
    chk("rx_data_kept", 32'(rx_data), 32'h34);
    cs_begin();
    rx_q.push_back(8'h81);
    xfer(8'h81, 8, 1'b0, 8'h00, miso);
    cs_end();

    // 5: early write then a write on the exact byte-start cycle
    cs_begin();
    tx_write(8'h11);
    rx_q.push_back(8'h5A);
    xfer(8'h5A, 8, 1'b1, 8'h22, miso);
    chk("tx_byte0", 32'(miso), 32'h00);
    rx_q.push_back(8'h3C);
    xfer(8'h3C, 8, 1'b0, 8'h00, miso);
    chk("tx_byte1_bypass", 32'(miso), 32'h22);
    rx_q.push_back(8'hC3);
    xfer(8'hC3, 8, 1'b0, 8'h00, miso);
    chk("tx_byte2", 32'(miso), 32'h00);
    cs_end();

    // 6: reset mid-byte, then a full frame
    cs_begin();
    xfer(8'hF0, 3, 1'b0, 8'h00, miso);
    @(negedge clk);
    reset_n  = 1'b0;
    spi_cs_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
    chk("mid_rst_oe", 32'(spi_cipo_oe), 32'd0);
    chk("mid_rst_cipo", 32'(spi_cipo), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
    chk("mid_rst_rx_strobe", 32'(rx_strobe), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    cs_begin();
    rx_q.push_back(8'h96);
    xfer(8'h96, 8, 1'b0, 8'h00, miso);
    chk("post_rst_tx", 32'(miso), 32'h00);
    cs_end();
    chk("post_rst_rx_data_final", 32'(rx_data), 32'h96);

    repeat (10) @(negedge clk);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
